// File: rtl/acf_block_normaliser_pkg.sv
// rtl/acf_block_normaliser_pkg.sv - shared constants and state encoding for the ACF block normaliser
package acf_block_normaliser_pkg;

    // Highest lag index; a block is ACF_LAGS+1 words, lag 0 first.
    localparam int ACF_LAGS      = 12;
    // Signed width of each incoming autocorrelation sum.
    localparam int ACF_IN_WIDTH  = 43;
    // Signed width of each normalised word handed to the Levinson stage.
    localparam int ACF_OUT_WIDTH = 32;
    // Shift field width; must be able to hold ACF_IN_WIDTH.
    localparam int ACF_SHIFT_W   = 6;

    // Capture the burst, compute the block shift, then stream it out.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_NORM    = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

endpackage

// File: rtl/acf_lzc.sv
// rtl/acf_lzc.sv - combinational leading-zero counter, all-zero input returns WIDTH
module acf_lzc
    import acf_block_normaliser_pkg::*;
#(
    parameter int WIDTH = ACF_IN_WIDTH,
    parameter int CNT_W = ACF_SHIFT_W
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan LSB to MSB so the highest set bit is the last one to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/acf_block_normaliser.sv
// rtl/acf_block_normaliser.sv - buffers an ACF burst and streams it block-normalised to the LPC stage
module acf_block_normaliser
    import acf_block_normaliser_pkg::*;
#(
    parameter int LAGS      = ACF_LAGS,
    parameter int IN_WIDTH  = ACF_IN_WIDTH,
    parameter int OUT_WIDTH = ACF_OUT_WIDTH,
    parameter int SHIFT_W   = ACF_SHIFT_W
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic                        iEnable,
    input  logic signed [IN_WIDTH-1:0]  iACF,
    input  logic                        iValid,
    input  logic                        iReady,
    output logic signed [OUT_WIDTH-1:0] oACF,
    output logic [3:0]                  oIndex,
    output logic [SHIFT_W-1:0]          oShift,
    output logic                        oValid,
    output logic                        oBusy,
    output logic                        oOverrun
);

    localparam logic [3:0]         LAST_IDX  = 4'(LAGS);
    localparam logic [SHIFT_W-1:0] SHIFT_ONE = SHIFT_W'(1);

    state_t                      state_q;
    state_t                      state_d;
    logic [3:0]                  wr_idx;
    logic [3:0]                  rd_idx;
    logic [3:0]                  pres_idx;
    logic signed [IN_WIDTH-1:0]  acf_buf [0:LAGS];
    logic [SHIFT_W-1:0]          lz;
    logic                        acf0_positive;
    logic [SHIFT_W-1:0]          norm_shift;
    logic signed [IN_WIDTH-1:0]  shifted;
    logic signed [OUT_WIDTH-1:0] out_word;
    logic                        word_in;
    logic                        handshake;

    acf_lzc #(
        .WIDTH (IN_WIDTH),
        .CNT_W (SHIFT_W)
    ) u_lzc (
        .value (acf_buf[0]),
        .count (lz)
    );

    assign word_in   = iEnable & iValid;
    assign handshake = iEnable & oValid & iReady;
    assign oBusy     = (state_q != ST_COLLECT);

    // ACF[0] <= 0 is a degenerate block and passes through unshifted; otherwise
    // the shift lands ACF[0]'s MSB one below the sign bit.
    assign acf0_positive = !acf_buf[0][IN_WIDTH-1] && (acf_buf[0] != '0);
    assign norm_shift    = acf0_positive ? (lz - SHIFT_ONE) : '0;

    // Word to present next: the current one on first entry to SEND, else its successor.
    assign pres_idx = (oValid && (rd_idx != LAST_IDX)) ? (rd_idx + 4'd1) : rd_idx;

    // |ACF[k]| <= ACF[0], so the left shift cannot overflow; the arithmetic right
    // shift then truncates toward -inf with no rounding.
    assign shifted  = acf_buf[pres_idx] <<< oShift;
    assign out_word = OUT_WIDTH'(shifted >>> (IN_WIDTH - OUT_WIDTH));

    // State register; reset wins over enable.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition requires an enabled cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (word_in && (wr_idx == LAST_IDX)) state_d = ST_NORM;
            ST_NORM:    if (iEnable) state_d = ST_SEND;
            ST_SEND:    if (handshake && (rd_idx == LAST_IDX)) state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // Capture buffer, shift register, output stream and overrun flag.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            oACF     <= '0;
            oIndex   <= '0;
            oShift   <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
            for (int i = 0; i <= LAGS; i++) begin
                acf_buf[i] <= '0;
            end
        end else if (iEnable) begin
            // Words arriving outside COLLECT are dropped and flagged.
            if (iValid && (state_q != ST_COLLECT)) begin
                oOverrun <= 1'b1;
            end
            case (state_q)
                ST_COLLECT: begin
                    if (iValid) begin
                        acf_buf[wr_idx] <= iACF;
                        wr_idx          <= (wr_idx == LAST_IDX) ? 4'd0 : (wr_idx + 4'd1);
                    end
                end
                ST_NORM: begin
                    oShift <= norm_shift;
                    rd_idx <= '0;
                end
                ST_SEND: begin
                    if (!oValid) begin
                        oValid <= 1'b1;
                        oACF   <= out_word;
                        oIndex <= rd_idx;
                    end else if (iReady) begin
                        if (rd_idx == LAST_IDX) begin
                            oValid <= 1'b0;
                            rd_idx <= '0;
                        end else begin
                            rd_idx <= pres_idx;
                            oACF   <= out_word;
                            oIndex <= pres_idx;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acf_block_normaliser.sv
// tb/tb_acf_block_normaliser.sv - scoreboard bench for acf_block_normaliser
module tb_acf_block_normaliser;

    logic        clk;
    logic        rst;
    logic        en;
    logic [42:0] acf_in;
    logic        vld_in;
    logic        rdy;
    logic [31:0] acf_out;
    logic [3:0]  idx_out;
    logic [5:0]  sh_out;
    logic        vld_out;
    logic        busy;
    logic        ovr;

    acf_block_normaliser dut (
        .iClock   (clk),
        .iReset   (rst),
        .iEnable  (en),
        .iACF     (acf_in),
        .iValid   (vld_in),
        .iReady   (rdy),
        .oACF     (acf_out),
        .oIndex   (idx_out),
        .oShift   (sh_out),
        .oValid   (vld_out),
        .oBusy    (busy),
        .oOverrun (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] acf;
        logic [3:0]  idx;
        logic [5:0]  sh;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [42:0] stim_w [0:12];
    logic [31:0] exp_o  [0:12];
    logic [5:0]  exp_sh;
    localparam logic [42:0] JUNK = 43'h2A5A5A5A5A5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (en && vld_out && rdy && !rst) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {60'd0, idx_out}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("oACF", {32'd0, acf_out}, {32'd0, e.acf});
                chk("oIndex", {60'd0, idx_out}, {60'd0, e.idx});
                chk("oShift", {58'd0, sh_out}, {58'd0, e.sh});
            end
        end
    end

    task automatic set_block(input int which);
        for (int k = 0; k < 13; k++) begin
            stim_w[k] = '0;
            exp_o[k]  = '0;
        end
        case (which)
            1: begin
                stim_w[0] = 43'd1 << 20;
                stim_w[1] = 43'd0 - 43'd524288;
                exp_o[0]  = 32'h4000_0000;
                exp_o[1]  = 32'hE000_0000;
                exp_sh    = 6'd21;
            end
            2: begin
                stim_w[0] = 43'd1;
                stim_w[1] = 43'd1;
                exp_o[0]  = 32'h4000_0000;
                exp_o[1]  = 32'h4000_0000;
                exp_sh    = 6'd41;
            end
            3: begin
                stim_w[0] = 43'd3 << 40;
                exp_o[0]  = 32'h6000_0000;
                exp_sh    = 6'd0;
            end
            4: begin
                exp_sh = 6'd0;
            end
            default: begin
                stim_w[0] = 43'd0 - 43'd5;
                stim_w[1] = 43'd4096;
                exp_o[0]  = 32'hFFFF_FFFF;
                exp_o[1]  = 32'd2;
                exp_sh    = 6'd0;
            end
        endcase
    endtask

    task automatic push_block();
        for (int k = 0; k < 13; k++) begin
            sb.push_back({exp_o[k], 4'(k), exp_sh});
        end
    endtask

    // Drives one burst; returns one #1 after the edge that stores the last word.
    task automatic drive_burst(input bit gaps, input int en_gap_at);
        for (int k = 0; k < 13; k++) begin
            if (k == en_gap_at) begin
                en = 1'b0; vld_in = 1'b1; acf_in = JUNK;
                repeat (4) @(posedge clk);
                #1 en = 1'b1;
            end
            vld_in = 1'b1; acf_in = stim_w[k];
            @(posedge clk); #1;
            vld_in = 1'b0; acf_in = JUNK;
            if (gaps && k != 12) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_idx(input logic [3:0] want);
        int n;
        n = 0;
        @(negedge clk);
        while (!(vld_out && idx_out == want) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idx_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || vld_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; acf_in = '0; vld_in = 1'b0; rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_oACF", {32'd0, acf_out}, 64'd0);
        chk("rst_oIndex", {60'd0, idx_out}, 64'd0);
        chk("rst_oShift", {58'd0, sh_out}, 64'd0);
        chk("rst_oValid", {63'd0, vld_out}, 64'd0);
        chk("rst_oBusy", {63'd0, busy}, 64'd0);
        chk("rst_oOverrun", {63'd0, ovr}, 64'd0);
        @(posedge clk); #1;

        // Scenario 1: latency and exact valid window at full rate.
        set_block(1); push_block();
        drive_burst(1'b0, -1);
        @(negedge clk);
        chk("s1_norm_valid", {63'd0, vld_out}, 64'd0);
        chk("s1_norm_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("s1_lat1_valid", {63'd0, vld_out}, 64'd0);
        @(negedge clk);
        chk("s1_first_valid", {63'd0, vld_out}, 64'd1);
        chk("s1_first_index", {60'd0, idx_out}, 64'd0);
        for (int k = 1; k < 13; k++) begin
            @(negedge clk);
            chk("s1_valid_window", {63'd0, vld_out}, 64'd1);
        end
        @(negedge clk);
        chk("s1_valid_end", {63'd0, vld_out}, 64'd0);
        wait_idle();

        // Scenario 2: shift extremes and degenerate blocks.
        for (int b = 2; b <= 5; b++) begin
            set_block(b); push_block();
            drive_burst(1'b0, -1);
            wait_idle();
        end

        // Scenario 3: gapped input, then backpressure at index 5.
        set_block(1); push_block();
        drive_burst(1'b1, -1);
        wait_idx(4'd4);
        @(posedge clk); #1 rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_hold_index", {60'd0, idx_out}, 64'd5);
            chk("s3_hold_valid", {63'd0, vld_out}, 64'd1);
            chk("s3_hold_acf", {32'd0, acf_out}, 64'd0);
        end
        @(posedge clk); #1 rdy = 1'b1;
        wait_idle();

        // Scenario 4: enable low in COLLECT, NORM and SEND.
        set_block(1); push_block();
        drive_burst(1'b0, 6);
        en = 1'b0; vld_in = 1'b1; acf_in = JUNK;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s4_norm_frozen_valid", {63'd0, vld_out}, 64'd0);
            chk("s4_norm_frozen_busy", {63'd0, busy}, 64'd1);
            @(posedge clk);
        end
        #1 en = 1'b1; vld_in = 1'b0;
        wait_idx(4'd3);
        @(posedge clk); #1 en = 1'b0; vld_in = 1'b1; acf_in = JUNK;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s4_send_frozen_index", {60'd0, idx_out}, 64'd4);
            chk("s4_send_frozen_valid", {63'd0, vld_out}, 64'd1);
            @(posedge clk);
        end
        #1 en = 1'b1; vld_in = 1'b0;
        wait_idle();
        chk("s4_no_overrun", {63'd0, ovr}, 64'd0);

        // Scenario 5: reset at input word 7 discards the partial burst.
        set_block(1);
        for (int k = 0; k < 7; k++) begin
            vld_in = 1'b1; acf_in = stim_w[k];
            @(posedge clk); #1;
        end
        vld_in = 1'b1; acf_in = stim_w[7]; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; vld_in = 1'b0;
        @(negedge clk);
        chk("s5_oACF", {32'd0, acf_out}, 64'd0);
        chk("s5_oIndex", {60'd0, idx_out}, 64'd0);
        chk("s5_oShift", {58'd0, sh_out}, 64'd0);
        chk("s5_oValid", {63'd0, vld_out}, 64'd0);
        chk("s5_oBusy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        set_block(2); push_block();
        drive_burst(1'b0, -1);
        wait_idle();

        // Scenario 6: word arriving on the last handshake cycle.
        set_block(3); push_block();
        drive_burst(1'b0, -1);
        wait_idx(4'd11);
        @(posedge clk); #1 vld_in = 1'b1; acf_in = JUNK;
        @(posedge clk); #1 vld_in = 1'b0;
        @(negedge clk);
        chk("s6_overrun_set", {63'd0, ovr}, 64'd1);
        chk("s6_back_to_collect", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        set_block(5); push_block();
        drive_burst(1'b0, -1);
        wait_idle();
        chk("s6_overrun_sticky", {63'd0, ovr}, 64'd1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
